// File: rtl/debounce_sync.sv
// debounce_sync: brings an asynchronous, possibly bouncy level into the clk
// domain through a SYNC_STAGES-deep synchronizer. A two-state counter FSM
// then debounces it. The block outputs the current/previous debounced sample
// pair for a downstream rising-edge detector (data_cur -> data_in1,
// data_prev -> data_in2).
//
// Optional feature: define DEBOUNCE_GLITCH_COUNT_EN to add glitch_cnt[7:0].
// This is a saturating count of candidate changes that were rejected as
// glitches.
//
// rst_n is asynchronous active-low. Its deassertion is assumed to be
// synchronized to clk outside this block.
module debounce_sync #(
    parameter int SYNC_STAGES  = 2,   // 2..4
    parameter int DEBOUNCE_CNT = 16,  // 1..2**CNT_W
    parameter int CNT_W        = 5    // must hold DEBOUNCE_CNT-1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       data_raw,
    output logic       data_cur,
    output logic       data_prev,
    output logic       busy
`ifdef DEBOUNCE_GLITCH_COUNT_EN
    ,
    output logic [7:0] glitch_cnt
`endif
);

    // Last count value of a qualification window. Reaching it while the
    // input is still mismatched accepts the change.
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CNT - 1);

    // busy is the state bit itself, so it is registered by construction.
    typedef enum logic {
        STABLE = 1'b0,
        CHECK  = 1'b1
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   sync_out;
    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   data_cur_q, data_cur_d;
    logic                   data_prev_q, data_prev_d;
`ifdef DEBOUNCE_GLITCH_COUNT_EN
    logic [7:0]             glitch_q, glitch_d;
    logic                   glitch_evt;
`endif

    assign sync_out = sync_q[SYNC_STAGES-1];

    // Synchronizer chain next value: pure shift, no other logic on the chain.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], data_raw};
    end

    // Synchronizer chain registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= '0;
        else        sync_q <= sync_d;
    end

    // Debounce next-state logic. A candidate change must stay mismatched for
    // DEBOUNCE_CNT consecutive CHECK cycles. Any return to data_cur aborts it.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        data_cur_d  = data_cur_q;
        data_prev_d = data_cur_q;
`ifdef DEBOUNCE_GLITCH_COUNT_EN
        glitch_evt  = 1'b0;
`endif
        case (state_q)
            STABLE: begin
                cnt_d = '0;
                if (sync_out != data_cur_q) state_d = CHECK;
            end
            CHECK: begin
                if (sync_out == data_cur_q) begin
                    state_d = STABLE;
                    cnt_d   = '0;
`ifdef DEBOUNCE_GLITCH_COUNT_EN
                    glitch_evt = 1'b1;
`endif
                end else if (cnt_q == CNT_MAX) begin
                    data_cur_d = sync_out;
                    state_d    = STABLE;
                    cnt_d      = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = STABLE;
                cnt_d   = '0;
            end
        endcase
    end

`ifdef DEBOUNCE_GLITCH_COUNT_EN
    // Saturating glitch counter next value.
    always_comb begin
        glitch_d = glitch_q;
        if (glitch_evt && glitch_q != 8'hFF) glitch_d = glitch_q + 8'd1;
    end
`endif

    // FSM, counter and output registers. All clear asynchronously on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= STABLE;
            cnt_q       <= '0;
            data_cur_q  <= 1'b0;
            data_prev_q <= 1'b0;
`ifdef DEBOUNCE_GLITCH_COUNT_EN
            glitch_q    <= 8'd0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            data_cur_q  <= data_cur_d;
            data_prev_q <= data_prev_d;
`ifdef DEBOUNCE_GLITCH_COUNT_EN
            glitch_q    <= glitch_d;
`endif
        end
    end

    assign data_cur  = data_cur_q;
    assign data_prev = data_prev_q;
    assign busy      = (state_q == CHECK);
`ifdef DEBOUNCE_GLITCH_COUNT_EN
    assign glitch_cnt = glitch_q;
`endif

endmodule

// File: tb/tb_debounce_sync.sv
// Directed bench for debounce_sync.
// DUT d0 uses the default parameters.
// DUT d1 uses SYNC_STAGES=3 and DEBOUNCE_CNT=1.
// Each output triple is packed as {data_cur, data_prev, busy}.
module tb_debounce_sync;

    logic clk = 1'b0;
    logic rst_n;
    logic raw0, raw1;
    logic cur0, prev0, busy0;
    logic cur1, prev1, busy1;
    logic [7:0] gc0, gc1;

    int total = 0;
    int passed = 0;

    always #5 clk = ~clk;

    debounce_sync d0 (
        .clk(clk), .rst_n(rst_n), .data_raw(raw0),
        .data_cur(cur0), .data_prev(prev0), .busy(busy0)
`ifdef DEBOUNCE_GLITCH_COUNT_EN
        , .glitch_cnt(gc0)
`endif
    );

    debounce_sync #(.SYNC_STAGES(3), .DEBOUNCE_CNT(1), .CNT_W(1)) d1 (
        .clk(clk), .rst_n(rst_n), .data_raw(raw1),
        .data_cur(cur1), .data_prev(prev1), .busy(busy1)
`ifdef DEBOUNCE_GLITCH_COUNT_EN
        , .glitch_cnt(gc1)
`endif
    );

`ifndef DEBOUNCE_GLITCH_COUNT_EN
    assign gc0 = 8'd0;
    assign gc1 = 8'd0;
`endif

    // Each record holds raw level, edges to apply, expected {cur,prev,busy}
    // after those edges, and expected glitch_cnt.
    typedef struct {
        logic       raw;
        int         n;
        logic [2:0] exp;
        int         glitch;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic chk_gc(input string nm, input logic [7:0] act, input int exp);
`ifdef DEBOUNCE_GLITCH_COUNT_EN
        chk(nm, int'(act), exp);
`endif
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic int t0();
        return int'({cur0, prev0, busy0});
    endfunction

    function automatic int t1();
        return int'({cur1, prev1, busy1});
    endfunction

    task automatic add(input logic r, input int n, input logic [2:0] e, input int g);
        vec_t v;
        v.raw = r; v.n = n; v.exp = e; v.glitch = g;
        vecs.push_back(v);
    endtask

    initial begin
        int moved;

        // Raise and hold: CHECK entered at edge 3; accepted at edge 19;
        // data_prev follows at edge 20.
        add(1, 2,  3'b000, 0);
        add(1, 1,  3'b001, 0);
        add(1, 15, 3'b001, 0);
        add(1, 1,  3'b100, 0);
        add(1, 1,  3'b110, 0);
        add(1, 10, 3'b110, 0);
        // Fall back to 0 with the same latency.
        add(0, 2,  3'b110, 0);
        add(0, 1,  3'b111, 0);
        add(0, 15, 3'b111, 0);
        add(0, 1,  3'b010, 0);
        add(0, 1,  3'b000, 0);
        add(0, 5,  3'b000, 0);
        // 5-cycle pulse: CHECK runs from edge 3; aborted at edge 8.
        add(1, 5,  3'b001, 0);
        add(0, 2,  3'b001, 0);
        add(0, 1,  3'b000, 1);
        add(0, 10, 3'b000, 1);
        // 16-cycle pulse: the return lands on the final count cycle (edge 19)
        // and still aborts.
        add(1, 16, 3'b001, 1);
        add(0, 2,  3'b001, 1);
        add(0, 1,  3'b000, 2);
        add(0, 5,  3'b000, 2);

        // Reset state: outputs clear asynchronously with no clock edge.
        raw0 = 0; raw1 = 0; rst_n = 1;
        #2 rst_n = 0;
        #1;
        chk("reset_d0", t0(), 0);
        chk("reset_d1", t1(), 0);
        chk_gc("reset_gc0", gc0, 0);
        tick(3);
        rst_n = 1;
        for (int i = 0; i < 50; i++) begin
            tick(1);
            chk("idle_d0", t0(), 0);
        end

        // Table-driven vectors.
        for (int i = 0; i < vecs.size(); i++) begin
            raw0 = vecs[i].raw;
            tick(vecs[i].n);
            chk($sformatf("vec%0d", i), t0(), int'(vecs[i].exp));
            chk_gc($sformatf("vec%0d_gc", i), gc0, vecs[i].glitch);
        end

        // Bounce 3 high / 3 low for 40 cycles. Seven aborted attempts;
        // the outputs never move.
        moved = 0;
        for (int i = 0; i < 40; i++) begin
            raw0 = ((i / 3) % 2) == 0;
            tick(1);
            if (cur0 || prev0) moved = 1;
        end
        chk("bounce_still", moved, 0);
        raw0 = 1;
        tick(18);
        chk("bounce_e18", t0(), 3'b001);
        chk_gc("bounce_gc", gc0, 9);
        tick(1);
        chk("bounce_e19", t0(), 3'b100);
        tick(1);
        chk("bounce_e20", t0(), 3'b110);

        // Return to 0, then reset in the middle of a 0->1 qualification
        // at cnt=10.
        raw0 = 0;
        tick(20);
        chk("fall_again", t0(), 3'b000);
        raw0 = 1;
        tick(13);
        chk("midcheck_busy", t0(), 3'b001);
        rst_n = 0;
        #1;
        chk("midcheck_rst", t0(), 0);
        chk_gc("midcheck_gc", gc0, 0);
        tick(3);
        rst_n = 1;
        // raw0 is held high through release, so it counts as a fresh 0->1.
        tick(18);
        chk("rel_e18", t0(), 3'b001);
        tick(1);
        chk("rel_e19", t0(), 3'b100);
        tick(1);
        chk("rel_e20", t0(), 3'b110);

        // DEBOUNCE_CNT=1, SYNC_STAGES=3, single-cycle pulse: seen at sync_q,
        // rejected.
        raw1 = 1;
        tick(1);
        raw1 = 0;
        tick(2);
        chk("d1p1_e3", t1(), 3'b000);
        tick(1);
        chk("d1p1_e4", t1(), 3'b001);
        tick(1);
        chk("d1p1_e5", t1(), 3'b000);
        tick(5);
        chk("d1p1_after", t1(), 3'b000);
        chk_gc("d1p1_gc", gc1, 1);

        // 2-cycle pulse: accepted at edge 5.
        raw1 = 1;
        tick(2);
        raw1 = 0;
        tick(2);
        chk("d1p2_e4", t1(), 3'b001);
        tick(1);
        chk("d1p2_e5", t1(), 3'b100);
        tick(1);
        chk("d1p2_e6", t1(), 3'b111);
        chk_gc("d1p2_gc", gc1, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
